uart_cmd_responder: RTL and testbench
=====================================

Name: uart_cmd_responder

Overview:
- Register-access responder on top of the byte-level UART engine.
- Collects 5-byte request frames from the UART receive byte stream and validates them.
- Executes a register write or read on a simple local register bus.
- Returns a 5-byte response frame through the UART transmit byte handshake. It is the device-side end of the host command protocol.

Parameters:
- HDR_REQ, 8'hA5, request header byte.
- HDR_RSP, 8'h5A, response header byte.
- TIMEOUT_CYCLES, 20000, maximum clk cycles allowed between consecutive request bytes.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- rx_data  in  8  received byte, valid with rx_valid
- rx_valid  in  1  one-cycle pulse, new received byte
- tx_data  out  8  byte to send; held stable from tx_start until tx_busy falls
- tx_start  out  1  one-cycle pulse requesting transmission of tx_data
- tx_busy  in  1  UART transmitter busy; rises one cycle after tx_start
- reg_addr  out  8  register address
- reg_wdata  out  8  register write data
- reg_we  out  1  one-cycle write strobe
- reg_re  out  1  one-cycle read strobe
- reg_rdata  in  8  read data, valid exactly one cycle after reg_re
- frame_err  out  1  one-cycle pulse on timeout or request dropped while busy

Behaviour:
- Reset values: tx_data 0, tx_start 0, reg_addr 0, reg_wdata 0, reg_we 0, reg_re 0, frame_err 0; state HUNT; all internal registers 0.
- Reset is async: asserting it mid-frame or mid-transmission aborts immediately. No response is sent afterwards.
- Request frame: HDR_REQ, CMD, ADDR, DATA, CHK, where CHK = CMD^ADDR^DATA. CMD 8'h01 is a write, CMD 8'h02 is a read. For a read, the DATA byte is don't-care but is included in CHK.
- Response frame: HDR_RSP, STATUS, ADDR, DATA, CHK, where CHK = STATUS^ADDR^DATA.
  - STATUS 8'h00 means ok.
  - STATUS 8'h01 means checksum error. The echoed DATA is the request DATA.
  - STATUS 8'h02 means unknown CMD. The echoed DATA is the request DATA.
  - For an ok read, DATA is reg_rdata. For an ok write, DATA echoes the written value.
- FSM states: HUNT, GET_CMD, GET_ADDR, GET_DATA, GET_CHK, EXEC, RD_WAIT, TX_LOAD, TX_WAIT.
  - HUNT: on rx_valid with rx_data==HDR_REQ go to GET_CMD. Any other byte is silently discarded.
  - GET_CMD, GET_ADDR, GET_DATA, GET_CHK: each captures one byte on rx_valid. Each advances one state; GET_CHK advances to EXEC.
  - Inter-byte timer: cleared on every accepted byte, counts while in GET_*. On reaching TIMEOUT_CYCLES, pulse frame_err and return to HUNT. No response is sent.
  - A byte equal to HDR_REQ inside GET_* is data, not a resync.
  - EXEC (1 cycle): evaluate checksum and CMD, with checksum checked first.
    - Ok write: reg_we=1 for this cycle with reg_addr/reg_wdata, then go to TX_LOAD.
    - Ok read: reg_re=1, then go to RD_WAIT.
    - Otherwise go to TX_LOAD with the error status.
  - RD_WAIT (1 cycle): latch reg_rdata into the response DATA, then go to TX_LOAD.
  - TX_LOAD: drive tx_data = response byte[idx] and pulse tx_start for one cycle, then go to TX_WAIT.
  - TX_WAIT: ignore the first cycle, since busy is not yet high. Then wait for tx_busy==0, increment idx, and return to TX_LOAD. After idx 4 completes, go to HUNT.
- Latency: a write strobe occurs 1 cycle after the rx_valid of CHK; the read strobe is likewise 1 cycle after that rx_valid. The first tx_start occurs 2 cycles after CHK for write/error and 3 cycles after CHK for read.
- rx_valid during EXEC, RD_WAIT or TX_*: the byte is dropped and frame_err pulses for one cycle. The FSM is unaffected.
- tx_data is registered and changes only in TX_LOAD.
- Response byte index is 3 bits and is cleared on entry to TX_LOAD from EXEC/RD_WAIT.
- Timeout counter width is $clog2(TIMEOUT_CYCLES+1). It saturates and cannot wrap.

Decomposition:
- Shared package uart_cmd_pkg:
  - State encoding constants.
  - CMD_WR=8'h01, CMD_RD=8'h02.
  - ST_OK=8'h00, ST_CHK=8'h01, ST_CMD=8'h02.
- No sub-module is needed. The inter-byte timeout counter is the only candidate (uart_byte_timer); keep it inline unless it is reused.

Test Plan:
- Write: A5 01 10 3C 2D -> reg_we pulse with addr 8'h10, wdata 8'h3C; response 5A 00 10 3C 2C.
- Read: A5 02 20 00 22, model returns reg_rdata 8'h77 -> reg_re pulse with addr 8'h20; response 5A 00 20 77 57.
- Bad checksum: A5 01 10 3C 00 -> no reg_we; response 5A 01 10 3C 2D.
- Bad command: A5 07 10 3C 2B -> no strobe; response 5A 02 10 3C 2E.
- Garbage and timeout:
  - 00 FF then A5 01 10 -> the leading bytes are ignored.
  - Next, TIMEOUT_CYCLES idle -> frame_err pulse and return to HUNT.
  - A following valid write frame then executes normally.
- Busy overlap and reset:
  - A byte sent during the response -> frame_err pulse, and the response bytes are unchanged.
  - Assert rst during the third response byte -> all outputs return to reset values, and no further tx_start occurs.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART register-access responder.
package uart_cmd_pkg;

    typedef enum logic [3:0] {
        S_HUNT     = 4'd0,
        S_GET_CMD  = 4'd1,
        S_GET_ADDR = 4'd2,
        S_GET_DATA = 4'd3,
        S_GET_CHK  = 4'd4,
        S_EXEC     = 4'd5,
        S_RD_WAIT  = 4'd6,
        S_TX_LOAD  = 4'd7,
        S_TX_WAIT  = 4'd8
    } state_e;

    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;

    localparam logic [7:0] ST_OK  = 8'h00;
    localparam logic [7:0] ST_CHK = 8'h01;
    localparam logic [7:0] ST_CMD = 8'h02;

    // Response frame byte selected by index: header, status, addr, data, checksum.
    function automatic logic [7:0] rsp_byte(input logic [2:0] idx,
                                            input logic [7:0] hdr,
                                            input logic [7:0] status,
                                            input logic [7:0] addr,
                                            input logic [7:0] data);
        logic [7:0] b;
        case (idx)
            3'd0:    b = hdr;
            3'd1:    b = status;
            3'd2:    b = addr;
            3'd3:    b = data;
            3'd4:    b = status ^ addr ^ data;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_cmd_responder_if.sv
// Byte-stream, transmit handshake and local register bus of the command responder.
interface uart_cmd_responder_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_busy;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_we;
   logic       reg_re;
   logic [7:0] reg_rdata;
   logic       frame_err;

   modport slave (
      input  rx_data, rx_valid, tx_busy, reg_rdata,
      output tx_data, tx_start, reg_addr, reg_wdata, reg_we, reg_re, frame_err
   );

   modport master (
      output rx_data, rx_valid, tx_busy, reg_rdata,
      input  tx_data, tx_start, reg_addr, reg_wdata, reg_we, reg_re, frame_err
   );
endinterface

// File: rtl/uart_cmd_responder.sv
// Device-side command responder: parses 5-byte requests, accesses the register
// bus and returns a 5-byte response through the UART transmit handshake.
module uart_cmd_responder
   import uart_cmd_pkg::*;
#(
   parameter logic [7:0] HDR_REQ        = 8'hA5,
   parameter logic [7:0] HDR_RSP        = 8'h5A,
   parameter int         TIMEOUT_CYCLES = 20000
) (
   input  logic                 clk,
   input  logic                 rst,
   uart_cmd_responder_if.slave  bus
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

   state_e        state_q, state_d;
   logic [7:0]    cmd_q, cmd_d;
   logic [7:0]    addr_q, addr_d;
   logic [7:0]    data_q, data_d;
   logic [7:0]    status_q, status_d;
   logic [7:0]    rsp_data_q, rsp_data_d;
   logic [2:0]    idx_q, idx_d;
   logic          first_q, first_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          tx_start_q, tx_start_d;
   logic [7:0]    reg_addr_q, reg_addr_d;
   logic [7:0]    reg_wdata_q, reg_wdata_d;
   logic          reg_we_q, reg_we_d;
   logic          reg_re_q, reg_re_d;
   logic          frame_err_q, frame_err_d;
   logic [7:0]    chk_calc_s;
   logic          busy_state_s;

   assign chk_calc_s = cmd_q ^ addr_q ^ data_q;
   assign busy_state_s = (state_q == S_EXEC) || (state_q == S_RD_WAIT) ||
                         (state_q == S_TX_LOAD) || (state_q == S_TX_WAIT);

   // Next-state and output decode for the request/response sequencer.
   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      addr_d      = addr_q;
      data_d      = data_q;
      status_d    = status_q;
      rsp_data_d  = rsp_data_q;
      idx_d       = idx_q;
      first_d     = first_q;
      timer_d     = timer_q;
      tx_data_d   = tx_data_q;
      tx_start_d  = 1'b0;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      reg_we_d    = 1'b0;
      reg_re_d    = 1'b0;
      frame_err_d = 1'b0;

      case (state_q)
         S_HUNT: begin
            timer_d = {TW{1'b0}};
            if (bus.rx_valid && (bus.rx_data == HDR_REQ)) begin
               state_d = S_GET_CMD;
            end else begin
               state_d = S_HUNT;
            end
         end
         S_GET_CMD, S_GET_ADDR, S_GET_DATA, S_GET_CHK: begin
            if (bus.rx_valid) begin
               timer_d = {TW{1'b0}};
               case (state_q)
                  S_GET_CMD:  begin cmd_d  = bus.rx_data; state_d = S_GET_ADDR; end
                  S_GET_ADDR: begin addr_d = bus.rx_data; state_d = S_GET_DATA; end
                  S_GET_DATA: begin data_d = bus.rx_data; state_d = S_GET_CHK;  end
                  default: begin
                     // Strobes are decided as CHK arrives so they land in EXEC.
                     state_d    = S_EXEC;
                     rsp_data_d = data_q;
                     reg_addr_d = addr_q;
                     if (bus.rx_data != chk_calc_s) begin
                        status_d = ST_CHK;
                     end else if (cmd_q == CMD_WR) begin
                        status_d    = ST_OK;
                        reg_wdata_d = data_q;
                        reg_we_d    = 1'b1;
                     end else if (cmd_q == CMD_RD) begin
                        status_d = ST_OK;
                        reg_re_d = 1'b1;
                     end else begin
                        status_d = ST_CMD;
                     end
                  end
               endcase
            end else if (timer_q == TMAX) begin
               timer_d     = {TW{1'b0}};
               frame_err_d = 1'b1;
               state_d     = S_HUNT;
            end else begin
               timer_d = timer_q + {{(TW-1){1'b0}}, 1'b1};
            end
         end
         S_EXEC: begin
            if ((status_q == ST_OK) && (cmd_q == CMD_RD)) begin
               state_d = S_RD_WAIT;
            end else begin
               idx_d      = 3'd0;
               tx_data_d  = rsp_byte(3'd0, HDR_RSP, status_q, addr_q, rsp_data_q);
               tx_start_d = 1'b1;
               state_d    = S_TX_LOAD;
            end
         end
         S_RD_WAIT: begin
            rsp_data_d = bus.reg_rdata;
            idx_d      = 3'd0;
            tx_data_d  = rsp_byte(3'd0, HDR_RSP, status_q, addr_q, bus.reg_rdata);
            tx_start_d = 1'b1;
            state_d    = S_TX_LOAD;
         end
         S_TX_LOAD: begin
            first_d = 1'b1;
            state_d = S_TX_WAIT;
         end
         S_TX_WAIT: begin
            if (first_q) begin
               first_d = 1'b0;
            end else if (!bus.tx_busy) begin
               if (idx_q == 3'd4) begin
                  state_d = S_HUNT;
               end else begin
                  idx_d      = idx_q + 3'd1;
                  tx_data_d  = rsp_byte(idx_q + 3'd1, HDR_RSP, status_q, addr_q, rsp_data_q);
                  tx_start_d = 1'b1;
                  state_d    = S_TX_LOAD;
               end
            end else begin
               state_d = S_TX_WAIT;
            end
         end
         default: begin
            state_d = S_HUNT;
         end
      endcase

      if (bus.rx_valid && busy_state_s) begin
         frame_err_d = 1'b1;
      end else begin
         frame_err_d = frame_err_d;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_HUNT;
         cmd_q       <= 8'h00;
         addr_q      <= 8'h00;
         data_q      <= 8'h00;
         status_q    <= 8'h00;
         rsp_data_q  <= 8'h00;
         idx_q       <= 3'd0;
         first_q     <= 1'b0;
         timer_q     <= {TW{1'b0}};
         tx_data_q   <= 8'h00;
         tx_start_q  <= 1'b0;
         reg_addr_q  <= 8'h00;
         reg_wdata_q <= 8'h00;
         reg_we_q    <= 1'b0;
         reg_re_q    <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         status_q    <= status_d;
         rsp_data_q  <= rsp_data_d;
         idx_q       <= idx_d;
         first_q     <= first_d;
         timer_q     <= timer_d;
         tx_data_q   <= tx_data_d;
         tx_start_q  <= tx_start_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         reg_we_q    <= reg_we_d;
         reg_re_q    <= reg_re_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign bus.tx_data   = tx_data_q;
   assign bus.tx_start  = tx_start_q;
   assign bus.reg_addr  = reg_addr_q;
   assign bus.reg_wdata = reg_wdata_q;
   assign bus.reg_we    = reg_we_q;
   assign bus.reg_re    = reg_re_q;
   assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Scoreboard bench for uart_cmd_responder with UART transmitter and register models.
module tb_uart_cmd_responder;

   localparam int TIMEOUT = 20000;

   logic clk = 1'b0;
   logic rst = 1'b1;

   uart_cmd_responder_if bus();

   uart_cmd_responder #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_rx_cyc = 0;

   logic [7:0] exp_q[$];
   logic [7:0] act_q[$];
   int         act_cyc_q[$];

   int start_cnt = 0, we_cnt = 0, re_cnt = 0, fe_cnt = 0;
   int we_cyc = 0, re_cyc = 0, fe_cyc = 0;
   logic [7:0] we_addr = 8'h00, we_data = 8'h00, re_addr = 8'h00;
   int busy_cnt = 0;

   // Free-running cycle counter used for latency measurements.
   always @(posedge clk) cyc <= cyc + 1;

   // Register read model: data is valid only in the cycle after reg_re.
   always @(posedge clk) bus.reg_rdata <= bus.reg_re ? 8'h77 : 8'hEE;

   // UART transmitter model: busy rises the cycle after tx_start, lasts 4 cycles.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_cnt    <= 0;
         bus.tx_busy <= 1'b0;
      end else if (bus.tx_start) begin
         busy_cnt    <= 4;
         bus.tx_busy <= 1'b1;
      end else if (busy_cnt != 0) begin
         busy_cnt    <= busy_cnt - 1;
         bus.tx_busy <= (busy_cnt != 1);
      end else begin
         bus.tx_busy <= 1'b0;
      end
   end

   // Output monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (bus.tx_start === 1'b1) begin
         act_q.push_back(bus.tx_data);
         act_cyc_q.push_back(cyc);
         start_cnt <= start_cnt + 1;
      end
      if (bus.reg_we === 1'b1) begin
         we_cnt  <= we_cnt + 1;
         we_addr <= bus.reg_addr;
         we_data <= bus.reg_wdata;
         we_cyc  <= cyc;
      end
      if (bus.reg_re === 1'b1) begin
         re_cnt  <= re_cnt + 1;
         re_addr <= bus.reg_addr;
         re_cyc  <= cyc;
      end
      if (bus.frame_err === 1'b1) begin
         fe_cnt <= fe_cnt + 1;
         fe_cyc <= cyc;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      last_rx_cyc  = cyc;
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] c, input logic [7:0] a,
                             input logic [7:0] d, input logic [7:0] k);
      send_byte(8'hA5);
      send_byte(c);
      send_byte(a);
      send_byte(d);
      send_byte(k);
   endtask

   task automatic push_exp(input logic [7:0] s, input logic [7:0] a, input logic [7:0] d);
      exp_q.push_back(8'h5A);
      exp_q.push_back(s);
      exp_q.push_back(a);
      exp_q.push_back(d);
      exp_q.push_back(s ^ a ^ d);
   endtask

   task automatic check_rsp(input string name, output int first_cyc);
      logic [7:0] a, e;
      first_cyc = -1;
      for (int i = 0; i < 5000 && act_q.size() < 5; i++) @(negedge clk);
      checks++;
      if (act_q.size() < 5) begin
         errors++;
         $display("FAIL %s: only %0d response bytes, required 5", name, act_q.size());
         act_q.delete();
         act_cyc_q.delete();
         exp_q.delete();
      end else begin
         first_cyc = act_cyc_q[0];
         for (int i = 0; i < 5; i++) begin
            a = act_q.pop_front();
            e = exp_q.pop_front();
            void'(act_cyc_q.pop_front());
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL %s byte %0d: got %h, required %h", name, i, a, e);
            end
         end
      end
      repeat (20) @(negedge clk);
   endtask

   task automatic check_idle_outputs(input string name);
      checks++;
      if ({bus.tx_data, bus.tx_start, bus.reg_addr, bus.reg_wdata,
           bus.reg_we, bus.reg_re, bus.frame_err} !== 29'd0) begin
         errors++;
         $display("FAIL %s: outputs tx_data=%h tx_start=%b addr=%h wdata=%h we=%b re=%b ferr=%b, required all 0",
                  name, bus.tx_data, bus.tx_start, bus.reg_addr, bus.reg_wdata,
                  bus.reg_we, bus.reg_re, bus.frame_err);
      end
   endtask

   task automatic check_int(input string name, input int got, input int req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, got, req);
      end
   endtask

   task automatic test_reset();
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset_hold");
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_outputs("after_reset");
   endtask

   task automatic test_write();
      int w0, fc, chk;
      w0 = we_cnt;
      send_frame(8'h01, 8'h10, 8'h3C, 8'h2D);
      chk = last_rx_cyc;
      push_exp(8'h00, 8'h10, 8'h3C);
      check_rsp("write", fc);
      check_int("write_we_count", we_cnt, w0 + 1);
      check_int("write_addr", int'(we_addr), 32'h10);
      check_int("write_wdata", int'(we_data), 32'h3C);
      check_int("write_we_latency", we_cyc - chk, 1);
      check_int("write_start_latency", fc - chk, 2);
   endtask

   task automatic test_read();
      int r0, w0, fc, chk;
      r0 = re_cnt;
      w0 = we_cnt;
      send_frame(8'h02, 8'h20, 8'h00, 8'h22);
      chk = last_rx_cyc;
      push_exp(8'h00, 8'h20, 8'h77);
      check_rsp("read", fc);
      check_int("read_re_count", re_cnt, r0 + 1);
      check_int("read_addr", int'(re_addr), 32'h20);
      check_int("read_re_latency", re_cyc - chk, 1);
      check_int("read_start_latency", fc - chk, 3);
      check_int("read_no_write", we_cnt, w0);
   endtask

   task automatic test_bad_chk();
      int w0, r0, fc, chk;
      w0 = we_cnt;
      r0 = re_cnt;
      send_frame(8'h01, 8'h10, 8'h3C, 8'h00);
      chk = last_rx_cyc;
      push_exp(8'h01, 8'h10, 8'h3C);
      check_rsp("bad_chk", fc);
      check_int("bad_chk_no_we", we_cnt, w0);
      check_int("bad_chk_no_re", re_cnt, r0);
      check_int("bad_chk_start_latency", fc - chk, 2);
   endtask

   task automatic test_bad_cmd();
      int w0, r0, fc;
      w0 = we_cnt;
      r0 = re_cnt;
      send_frame(8'h07, 8'h10, 8'h3C, 8'h2B);
      push_exp(8'h02, 8'h10, 8'h3C);
      check_rsp("bad_cmd", fc);
      check_int("bad_cmd_no_we", we_cnt, w0);
      check_int("bad_cmd_no_re", re_cnt, r0);
   endtask

   task automatic test_garbage_timeout();
      int f0, s0, w0, lrx, fc;
      f0 = fe_cnt;
      s0 = start_cnt;
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h10);
      lrx = last_rx_cyc;
      for (int i = 0; i < TIMEOUT + 5000 && fe_cnt == f0; i++) @(negedge clk);
      check_int("timeout_frame_err", fe_cnt, f0 + 1);
      checks++;
      if ((fe_cyc - lrx) < TIMEOUT || (fe_cyc - lrx) > TIMEOUT + 2) begin
         errors++;
         $display("FAIL timeout_delay: got %0d cycles, required %0d..%0d",
                  fe_cyc - lrx, TIMEOUT, TIMEOUT + 2);
      end
      check_int("timeout_no_tx", start_cnt, s0);
      w0 = we_cnt;
      send_frame(8'h01, 8'h33, 8'hC4, 8'h01 ^ 8'h33 ^ 8'hC4);
      push_exp(8'h00, 8'h33, 8'hC4);
      check_rsp("after_timeout", fc);
      check_int("after_timeout_we", we_cnt, w0 + 1);
      check_int("after_timeout_wdata", int'(we_data), 32'hC4);
   endtask

   task automatic test_busy_overlap();
      int f0, s0, fc;
      s0 = start_cnt;
      send_frame(8'h01, 8'h44, 8'h12, 8'h01 ^ 8'h44 ^ 8'h12);
      push_exp(8'h00, 8'h44, 8'h12);
      for (int i = 0; i < 200 && start_cnt == s0; i++) @(negedge clk);
      f0 = fe_cnt;
      send_byte(8'hA5);
      repeat (2) @(negedge clk);
      check_int("overlap_frame_err", fe_cnt, f0 + 1);
      check_rsp("overlap", fc);
      repeat (50) @(negedge clk);
      check_int("overlap_start_count", start_cnt, s0 + 5);
   endtask

   task automatic test_reset_mid_tx();
      int s0, s1;
      s0 = start_cnt;
      send_frame(8'h01, 8'h55, 8'hAA, 8'h01 ^ 8'h55 ^ 8'hAA);
      for (int i = 0; i < 500 && start_cnt < s0 + 3; i++) @(negedge clk);
      check_int("reset_mid_reached_byte3", start_cnt, s0 + 3);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_idle_outputs("reset_mid_tx");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      s1 = start_cnt;
      repeat (200) @(negedge clk);
      check_int("reset_no_more_tx", start_cnt, s1);
      check_idle_outputs("reset_mid_tx_after");
      act_q.delete();
      act_cyc_q.delete();
      exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_bad_chk();
      test_bad_cmd();
      test_garbage_timeout();
      test_busy_overlap();
      test_reset_mid_tx();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
